// File: rtl/arty_wrapper_uart_controller_pkg.sv
// Shared types and constants for the Arty UART controller.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned DATA_BITS            = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/arty_wrapper_uart_controller_if.sv
// Fabric-side byte interface: TX valid/ready handshake and RX strobes.
interface arty_wrapper_uart_controller_if;

    logic [uart_pkg::DATA_BITS-1:0] tx_data;
    logic                           tx_valid;
    logic                           tx_ready;
    logic [uart_pkg::DATA_BITS-1:0] rx_data;
    logic                           rx_valid;
    logic                           rx_frame_err;

    // Fabric logic producing/consuming bytes.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err
    );

    // UART controller.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output rx_frame_err
    );

endinterface

// File: rtl/arty_wrapper_uart_controller_rx_deser.sv
// UART receiver: 2-flop synchroniser, 8N1 deserialiser, good-frame and
// framing-error strobes.
module uart_rx_deser #(
    parameter int unsigned CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 rx_frame_err_o
);
    import uart_pkg::*;

    localparam int unsigned    CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rxs;
    logic                 rxs_prev_q;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    assign rxs = sync_q[1];

    // Synchronise the asynchronous pin and keep last sample for edge detect.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rxd_i};
            rxs_prev_q <= rxs;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state: half-bit start check, then sample at each bit centre.
    // A start is only armed by a high-to-low edge, so after a break the
    // line must return high before the next frame is recognised.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_data_o      = data_q;
    assign rx_valid_o     = valid_q;
    assign rx_frame_err_o = ferr_q;

endmodule

// File: rtl/arty_wrapper_uart_controller.sv
// Arty UART controller top: inline 8N1 transmitter plus receiver sub-module.
module arty_wrapper_uart_controller #(
    parameter int unsigned CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                          CLK100MHZ,
    input  logic                          rst_p,
    input  logic                          uart_rxd,
    output logic                          uart_txd,
    arty_wrapper_uart_controller_if.slave bus
);
    import uart_pkg::*;

    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 txd_q, txd_d;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;

    // TX state and datapath registers; reset forces the line high at once.
    always_ff @(posedge CLK100MHZ or posedge rst_p) begin
        if (rst_p) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    // Next-state: the line level is computed alongside each transition so
    // the pin is driven straight from a flop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (bus.tx_valid) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = bus.tx_data;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                txd_d = 1'b1;
                if (tx_cnt_q == LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign uart_txd     = txd_q;
    assign bus.tx_ready = (tx_state_q == TX_IDLE);

    uart_rx_deser #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS)
    ) u_rx (
        .clk_i          (CLK100MHZ),
        .rst_i          (rst_p),
        .rxd_i          (uart_rxd),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_frame_err_o (rx_frame_err)
    );

    assign bus.rx_data      = rx_data;
    assign bus.rx_valid     = rx_valid;
    assign bus.rx_frame_err = rx_frame_err;

endmodule

// File: tb/tb_arty_wrapper_uart_controller.sv
// Directed + randomized bench for the Arty UART controller at 10 clocks/bit.
module tb_arty_wrapper_uart_controller;

    localparam int unsigned CPB   = 10;
    localparam int unsigned FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst_p;
    logic rxd;
    logic txd;
    logic rxd_drv = 1'b1;
    logic loop_en = 1'b0;

    int unsigned checks   = 0;
    int unsigned errors   = 0;
    int unsigned ferr_cnt = 0;
    logic [7:0]  rxq[$];

    always #5 clk = ~clk;

    assign rxd = loop_en ? txd : rxd_drv;

    arty_wrapper_uart_controller_if bus();

    arty_wrapper_uart_controller #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK100MHZ (clk),
        .rst_p     (rst_p),
        .uart_rxd  (rxd),
        .uart_txd  (txd),
        .bus       (bus)
    );

    // Record every received byte and framing-error strobe.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rxq.push_back(bus.rx_data);
        if (bus.rx_frame_err === 1'b1) ferr_cnt++;
    end

    // Reference line level for bit slot k of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte for a single cycle and compare the whole frame.
    task automatic send_and_check(input logic [7:0] b, input string tag);
        int unsigned bad  = 0;
        int unsigned busy = 0;
        check({tag, "_ready_before"}, 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~b;
        for (int unsigned c = 0; c < FRAME; c++) begin
            if (txd !== frame_bit(b, c / CPB)) bad++;
            if (bus.tx_ready === 1'b0) busy++;
            @(negedge clk);
        end
        check({tag, "_wave_mismatch_cycles"}, bad, 32'd0);
        check({tag, "_ready_low_cycles"}, busy, FRAME);
        check({tag, "_ready_after"}, 32'(bus.tx_ready), 32'd1);
        check({tag, "_txd_idle"}, 32'(txd), 32'd1);
    endtask

    // Drive one frame onto the RX pin; stop selects the stop-bit level.
    task automatic rx_send(input logic [7:0] b, input logic stop);
        for (int unsigned k = 0; k < 10; k++) begin
            rxd_drv = (k == 9) ? stop : frame_bit(b, k);
            repeat (CPB) @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask

    initial begin
        logic [7:0]  exp_q[$];
        logic [7:0]  last_good;
        logic [7:0]  b;
        logic        exp_txd;
        logic        prev_rdy;
        int unsigned bad;
        int unsigned rises;
        int unsigned ferr0;

        rst_p        = 1'b1;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_frame_err", 32'(bus.rx_frame_err), 32'd0);
        rst_p = 1'b0;
        @(negedge clk);

        // Reset during a frame: 0x96 D0 slot is low, reset must raise the line.
        bus.tx_data  = 8'h96;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("midframe_txd_low", 32'(txd), 32'd0);
        check("midframe_busy", 32'(bus.tx_ready), 32'd0);
        rst_p = 1'b1;
        #1;
        check("async_rst_txd", 32'(txd), 32'd1);
        check("async_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("async_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_p = 1'b0;
        @(negedge clk);
        send_and_check(8'h55, "post_reset_55");

        send_and_check(8'hA5, "tx_A5");

        // Back-to-back: 0x00 then 0xFF with tx_valid held, one idle cycle between.
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'hFF;
        bad      = 0;
        rises    = 0;
        prev_rdy = 1'b0;
        for (int unsigned c = 0; c <= 2 * FRAME; c++) begin
            if (c < FRAME)       exp_txd = frame_bit(8'h00, c / CPB);
            else if (c == FRAME) exp_txd = 1'b1;
            else                 exp_txd = frame_bit(8'hFF, (c - FRAME - 1) / CPB);
            if (txd !== exp_txd) bad++;
            if (bus.tx_ready !== (c == FRAME)) bad++;
            if (bus.tx_ready === 1'b1 && prev_rdy === 1'b0) rises++;
            prev_rdy = bus.tx_ready;
            if (c == FRAME + 1) bus.tx_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_mismatch_cycles", bad, 32'd0);
        check("b2b_ready_rises", rises, 32'd1);
        check("b2b_ready_after", 32'(bus.tx_ready), 32'd1);

        for (int unsigned i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send_and_check(b, "tx_rand");
        end

        // RX good frame.
        rxq.delete();
        ferr0 = ferr_cnt;
        rx_send(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        check("rx3C_count", 32'(rxq.size()), 32'd1);
        check("rx3C_data_strobed", 32'(rxq[0]), 32'h3C);
        check("rx3C_data_held", 32'(bus.rx_data), 32'h3C);
        check("rx3C_no_ferr", ferr_cnt - ferr0, 32'd0);
        last_good = 8'h3C;

        // Short low glitch must not start a frame.
        rxq.delete();
        ferr0   = ferr_cnt;
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_valid", 32'(rxq.size()), 32'd0);
        check("glitch_no_ferr", ferr_cnt - ferr0, 32'd0);

        // Bad stop bit.
        rxq.delete();
        ferr0 = ferr_cnt;
        rx_send(8'h81, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_pulses", ferr_cnt - ferr0, 32'd1);
        check("ferr_no_valid", 32'(rxq.size()), 32'd0);
        check("ferr_rx_data_kept", 32'(bus.rx_data), 32'(last_good));

        // Randomized good frames.
        rxq.delete();
        ferr0 = ferr_cnt;
        exp_q.delete();
        for (int unsigned i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            last_good = b;
            rx_send(b, 1'b1);
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("rx_rand_count", 32'(rxq.size()), 32'd4);
        for (int unsigned i = 0; i < 4; i++) check("rx_rand_data", 32'(rxq[i]), 32'(exp_q[i]));
        check("rx_rand_last", 32'(bus.rx_data), 32'(last_good));
        check("rx_rand_no_ferr", ferr_cnt - ferr0, 32'd0);

        // External loopback.
        loop_en = 1'b1;
        repeat (5) @(negedge clk);
        rxq.delete();
        ferr0 = ferr_cnt;
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'hFF);
        for (int unsigned i = 0; i < 3; i++) send_and_check(exp_q[i], "loop_tx");
        repeat (30) @(negedge clk);
        check("loop_count", 32'(rxq.size()), 32'd3);
        for (int unsigned i = 0; i < 3; i++) check("loop_data", 32'(rxq[i]), 32'(exp_q[i]));
        check("loop_no_ferr", ferr_cnt - ferr0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
